// File: rtl/cp0_tlb_index_unit_if.sv
// Bus between the CP0 core and the TLB index unit.
// The unit itself sits on the slave side. The CP0 core, or the bench, drives the master side.
interface cp0_tlb_index_unit_if #(
  parameter int IDX_W = 4
);
  logic             stall;
  logic [31:0]      wired_in;
  logic             wired_we;
  logic             index_we;
  logic [31:0]      mtc_data;
  logic             tlbp_valid;
  logic             tlbp_hit;
  logic [IDX_W-1:0] tlbp_idx;
  logic             tlbwi;
  logic             tlbwr;
  logic [31:0]      index_q;
  logic [31:0]      random_q;
  logic             tlb_we;
  logic [IDX_W-1:0] tlb_widx;

  modport master (
    output stall, wired_in, wired_we, index_we, mtc_data,
           tlbp_valid, tlbp_hit, tlbp_idx, tlbwi, tlbwr,
    input  index_q, random_q, tlb_we, tlb_widx
  );

  modport slave (
    input  stall, wired_in, wired_we, index_we, mtc_data,
           tlbp_valid, tlbp_hit, tlbp_idx, tlbwi, tlbwr,
    output index_q, random_q, tlb_we, tlb_widx
  );
endinterface

// File: rtl/cp0_tlb_index_unit.sv
// CP0 TLB index unit.
// It holds the Random register, which counts down from the top entry to Wired and then wraps.
// It holds the Index register, which MTC0 and TLBP update.
// It produces a registered write strobe and entry number for TLBWI and TLBWR.
module cp0_tlb_index_unit #(
  parameter int TLB_ENTRIES = 16,
  parameter int IDX_W       = 4
) (
  input logic                 clk,
  input logic                 rst,
  cp0_tlb_index_unit_if.slave bus
);

  localparam logic [IDX_W-1:0] TOP_IDX = IDX_W'(TLB_ENTRIES - 1);
  localparam logic [IDX_W-1:0] ONE_IDX = IDX_W'(1);

  logic [IDX_W-1:0] wired_eff_s;
  logic [IDX_W-1:0] random_r;
  logic [IDX_W-1:0] random_s;
  logic [IDX_W-1:0] idx_r;
  logic [IDX_W-1:0] idx_s;
  logic             p_r;
  logic             p_s;
  logic             tlb_we_r;
  logic             tlb_we_s;
  logic [IDX_W-1:0] tlb_widx_r;
  logic [IDX_W-1:0] tlb_widx_s;
  logic             unused_bits_s;

  assign wired_eff_s   = bus.wired_in[IDX_W-1:0];
  assign unused_bits_s = ^{bus.wired_in[31:IDX_W], bus.mtc_data[31:IDX_W]};

  // Random next value.
  // A Wired write reloads the counter even while the pipeline is stalled.
  // A Wired value beyond the last entry pins the counter at the top.
  always_comb begin
    random_s = random_r;
    if (bus.wired_we) begin
      random_s = TOP_IDX;
    end else if (bus.stall) begin
      random_s = random_r;
    end else if (wired_eff_s > TOP_IDX) begin
      random_s = TOP_IDX;
    end else if (random_r <= wired_eff_s) begin
      random_s = TOP_IDX;
    end else begin
      random_s = random_r - ONE_IDX;
    end
  end

  // Index next value.
  // An MTC0 write takes precedence and drops a same-cycle TLBP result.
  // P is only ever set or cleared by TLBP.
  always_comb begin
    idx_s = idx_r;
    p_s   = p_r;
    if (bus.stall) begin
      idx_s = idx_r;
      p_s   = p_r;
    end else if (bus.index_we) begin
      idx_s = bus.mtc_data[IDX_W-1:0];
    end else if (bus.tlbp_valid) begin
      if (bus.tlbp_hit) begin
        p_s   = 1'b0;
        idx_s = bus.tlbp_idx;
      end else begin
        p_s   = 1'b1;
      end
    end else begin
      idx_s = idx_r;
      p_s   = p_r;
    end
  end

  // TLB write request.
  // The entry number comes from the pre-update Index or Random value, and TLBWI wins over TLBWR.
  always_comb begin
    tlb_we_s   = 1'b0;
    tlb_widx_s = tlb_widx_r;
    if (bus.stall) begin
      tlb_we_s = 1'b0;
    end else if (bus.tlbwi) begin
      tlb_we_s   = 1'b1;
      tlb_widx_s = idx_r;
    end else if (bus.tlbwr) begin
      tlb_we_s   = 1'b1;
      tlb_widx_s = random_r;
    end else begin
      tlb_we_s = 1'b0;
    end
  end

  // State registers, cleared asynchronously by rst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      random_r   <= TOP_IDX;
      idx_r      <= {IDX_W{1'b0}};
      p_r        <= 1'b0;
      tlb_we_r   <= 1'b0;
      tlb_widx_r <= {IDX_W{1'b0}};
    end else begin
      random_r   <= random_s;
      idx_r      <= idx_s;
      p_r        <= p_s;
      tlb_we_r   <= tlb_we_s;
      tlb_widx_r <= tlb_widx_s;
    end
  end

  assign bus.index_q  = {p_r, {(31 - IDX_W){1'b0}}, idx_r};
  assign bus.random_q = {{(32 - IDX_W){1'b0}}, random_r};
  assign bus.tlb_we   = tlb_we_r;
  assign bus.tlb_widx = tlb_widx_r;

endmodule

// File: tb/tb_cp0_tlb_index_unit.sv
// Bench for cp0_tlb_index_unit.
// It runs directed scenarios followed by random traffic.
// Every output is compared against an integer reference model.
module tb_cp0_tlb_index_unit;
  localparam int N = 16;
  localparam int W = 4;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  // reference model state
  int m_random;
  int m_idx;
  int m_p;
  int m_we;
  int m_widx;

  always #5 clk = ~clk;

  cp0_tlb_index_unit_if #(.IDX_W(W)) bus ();

  cp0_tlb_index_unit #(.TLB_ENTRIES(N), .IDX_W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_random = N - 1;
    m_idx    = 0;
    m_p      = 0;
    m_we     = 0;
    m_widx   = 0;
  endtask

  // Advances the model by one clock edge, using the inputs as they were at that edge.
  task automatic model_step();
    int wired;
    int old_idx;
    int old_rand;
    wired    = int'(bus.wired_in) & ((1 << W) - 1);
    old_idx  = m_idx;
    old_rand = m_random;
    if (bus.stall) m_we = 0;
    else if (bus.tlbwi) begin m_we = 1; m_widx = old_idx; end
    else if (bus.tlbwr) begin m_we = 1; m_widx = old_rand; end
    else m_we = 0;
    if (bus.wired_we) m_random = N - 1;
    else if (!bus.stall) m_random = (wired > N - 1 || old_rand <= wired) ? N - 1 : old_rand - 1;
    if (!bus.stall) begin
      if (bus.index_we) m_idx = int'(bus.mtc_data) & ((1 << W) - 1);
      else if (bus.tlbp_valid && bus.tlbp_hit) begin m_p = 0; m_idx = int'(bus.tlbp_idx); end
      else if (bus.tlbp_valid) m_p = 1;
    end
  endtask

  task automatic check_all(input string tag);
    logic [31:0] e_index;
    e_index     = 32'(m_idx);
    e_index[31] = (m_p != 0);
    check_value({tag, ".random_q"}, bus.random_q, 32'(m_random));
    check_value({tag, ".index_q"}, bus.index_q, e_index);
    check_value({tag, ".tlb_we"}, {31'd0, bus.tlb_we}, 32'(m_we));
    check_value({tag, ".tlb_widx"}, {28'd0, bus.tlb_widx}, 32'(m_widx));
  endtask

  task automatic cycle(input string tag);
    @(posedge clk);
    model_step();
    #1;
    check_all(tag);
  endtask

  task automatic idle();
    bus.stall      = 1'b0;
    bus.wired_we   = 1'b0;
    bus.index_we   = 1'b0;
    bus.tlbp_valid = 1'b0;
    bus.tlbp_hit   = 1'b0;
    bus.tlbwi      = 1'b0;
    bus.tlbwr      = 1'b0;
  endtask

  // Steps plain cycles until the model's Random equals target, with a bounded number of tries.
  // It then checks that the design has reached the same value.
  task automatic run_to(input int target, input string tag);
    for (int i = 0; i < 40 && m_random != target; i++) cycle(tag);
    check_value({tag, ".reach"}, bus.random_q, 32'(target));
  endtask

  initial begin
    rst = 1'b1;
    idle();
    bus.wired_in = 32'd0;
    bus.mtc_data = 32'd0;
    bus.tlbp_idx = 4'd0;
    model_reset();
    #12;
    rst = 1'b0;
    check_all("reset");

    // free-running count with Wired = 0
    for (int k = 0; k < 19; k++) cycle("count0");
    check_value("count0.end", bus.random_q, 32'd12);

    // Wired = 4: the old value is still visible during the write cycle
    bus.wired_we = 1'b1;
    cycle("wired_wr");
    check_value("wired_wr.reload", bus.random_q, 32'd15);
    idle();
    bus.wired_in = 32'd4;
    for (int k = 0; k < 12; k++) cycle("count4");
    check_value("count4.wrap", bus.random_q, 32'd15);
    run_to(9, "to9");
    bus.wired_we = 1'b1;
    cycle("rewire");
    check_value("rewire.reload", bus.random_q, 32'd15);
    idle();

    // stall with a pending TLBWR
    run_to(11, "to11");
    bus.stall = 1'b1;
    bus.tlbwr = 1'b1;
    for (int k = 0; k < 5; k++) cycle("stall");
    check_value("stall.random", bus.random_q, 32'd11);
    check_value("stall.we", {31'd0, bus.tlb_we}, 32'd0);
    bus.wired_we = 1'b1;
    cycle("stall_wired");
    check_value("stall_wired.random", bus.random_q, 32'd15);
    idle();

    // Index updates from TLBP and MTC0
    bus.tlbp_valid = 1'b1; bus.tlbp_hit = 1'b1; bus.tlbp_idx = 4'd7;
    cycle("tlbp_hit");
    check_value("tlbp_hit.idx", bus.index_q, 32'h0000_0007);
    bus.tlbp_hit = 1'b0;
    cycle("tlbp_miss");
    check_value("tlbp_miss.idx", bus.index_q, 32'h8000_0007);
    idle();
    bus.index_we = 1'b1; bus.mtc_data = 32'hFFFF_FFF3;
    cycle("mtc0");
    check_value("mtc0.idx", bus.index_q, 32'h8000_0003);
    bus.mtc_data = 32'd2;
    bus.tlbp_valid = 1'b1; bus.tlbp_hit = 1'b1; bus.tlbp_idx = 4'd9;
    cycle("mtc0_tlbp");
    check_value("mtc0_tlbp.idx", bus.index_q, 32'h8000_0002);
    idle();

    // TLB write port
    bus.index_we = 1'b1; bus.mtc_data = 32'd3;
    cycle("set3");
    idle();
    bus.tlbwi = 1'b1;
    cycle("tlbwi");
    check_value("tlbwi.widx", {28'd0, bus.tlb_widx}, 32'd3);
    idle();
    cycle("tlbwi_off");
    check_value("tlbwi_off.we", {31'd0, bus.tlb_we}, 32'd0);
    run_to(10, "to10");
    bus.tlbwr = 1'b1;
    cycle("tlbwr");
    check_value("tlbwr.widx", {28'd0, bus.tlb_widx}, 32'd10);
    bus.tlbwi = 1'b1;
    cycle("tlbwi_wr");
    check_value("tlbwi_wr.widx", {28'd0, bus.tlb_widx}, 32'd3);
    bus.tlbwr = 1'b0;
    bus.index_we = 1'b1; bus.mtc_data = 32'd5;
    cycle("tlbwi_mtc");
    check_value("tlbwi_mtc.widx", {28'd0, bus.tlb_widx}, 32'd3);
    idle();

    // asynchronous reset between edges
    run_to(7, "to7");
    bus.tlbwr = 1'b1;
    cycle("pre_rst");
    idle();
    check_value("pre_rst.random", bus.random_q, 32'd6);
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_all("async_rst");
    #2 rst = 1'b0;
    cycle("post_rst");
    check_value("post_rst.random", bus.random_q, 32'd14);

    // random traffic
    for (int k = 0; k < 400; k++) begin
      bus.stall      = ($urandom_range(0, 3) == 32'd0);
      bus.wired_we   = ($urandom_range(0, 9) == 32'd0);
      bus.wired_in   = $urandom;
      bus.index_we   = ($urandom_range(0, 7) == 32'd0);
      bus.mtc_data   = $urandom;
      bus.tlbp_valid = ($urandom_range(0, 3) == 32'd0);
      bus.tlbp_hit   = ($urandom_range(0, 1) == 32'd0);
      bus.tlbp_idx   = W'($urandom_range(0, N - 1));
      bus.tlbwi      = ($urandom_range(0, 5) == 32'd0);
      bus.tlbwr      = ($urandom_range(0, 5) == 32'd0);
      cycle("rand");
      if ($urandom_range(0, 39) == 32'd0) begin
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_all("rand_rst");
        #2 rst = 1'b0;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
